// File: rtl/bram_dwc_seq.sv
// Wide-to-narrow BRAM width converter: splits one master access into R narrow
// beats, then reassembles read beats into a single wide response.
module bram_dwc_seq #(
  parameter int MST_DATA_BITW = 64,
  parameter int SLV_DATA_BITW = 32,
  parameter int ADDR_BITW     = 32,
  parameter int RD_LATENCY    = 1
) (
  input  logic                       Clk_CI,
  input  logic                       Rst_RI,
  input  logic                       Req_SI,
  output logic                       Gnt_SO,
  input  logic [ADDR_BITW-1:0]       Addr_DI,
  input  logic [MST_DATA_BITW/8-1:0] WrEn_SI,
  input  logic [MST_DATA_BITW-1:0]   Wr_DI,
  output logic                       RdValid_SO,
  output logic [MST_DATA_BITW-1:0]   Rd_DO,
  output logic                       En_SO,
  output logic [ADDR_BITW-1:0]       Addr_DO,
  output logic [SLV_DATA_BITW/8-1:0] WrEn_SO,
  output logic [SLV_DATA_BITW-1:0]   Wr_DO,
  input  logic [SLV_DATA_BITW-1:0]   Rd_DI,
  output logic [1:0]                 dbg_state
);

  localparam int R    = MST_DATA_BITW / SLV_DATA_BITW;
  localparam int MB   = MST_DATA_BITW / 8;
  localparam int SB   = SLV_DATA_BITW / 8;
  localparam int KW   = (R > 1) ? $clog2(R) : 1;
  localparam int AOFF = $clog2(MB);
  localparam logic [ADDR_BITW-1:0] ALIGN_MASK = {ADDR_BITW{1'b1}} << AOFF;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, RESP = 2'd3} state_t;

  state_t                    state;
  logic [KW-1:0]             k;
  logic                      is_wr;
  logic [MST_DATA_BITW-1:0]  wdata;
  logic [MB-1:0]             wen;
  logic [MST_DATA_BITW-1:0]  cap;
  logic [MST_DATA_BITW-1:0]  cap_next;
  logic                      pipe_vld [RD_LATENCY];
  logic [KW-1:0]             pipe_idx [RD_LATENCY];
  logic                      last_cap;

  assign Gnt_SO    = (state == IDLE) && !Rst_RI;
  assign dbg_state = state;

  // The oldest pipeline stage marks the cycle in which Rd_DI carries that beat.
  always_comb begin
    cap_next = cap;
    if (pipe_vld[RD_LATENCY-1]) begin
      for (int b = 0; b < R; b++) begin
        if (pipe_idx[RD_LATENCY-1] == KW'(b))
          cap_next[b*SLV_DATA_BITW +: SLV_DATA_BITW] = Rd_DI;
      end
    end
  end

  assign last_cap = pipe_vld[RD_LATENCY-1] && (pipe_idx[RD_LATENCY-1] == KW'(R-1));

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state      <= IDLE;
      k          <= '0;
      is_wr      <= 1'b0;
      wdata      <= '0;
      wen        <= '0;
      cap        <= '0;
      En_SO      <= 1'b0;
      Addr_DO    <= '0;
      WrEn_SO    <= '0;
      Wr_DO      <= '0;
      RdValid_SO <= 1'b0;
      Rd_DO      <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_idx[i] <= '0;
      end
    end else begin
      RdValid_SO  <= 1'b0;
      cap         <= cap_next;
      pipe_vld[0] <= (state == ISSUE) && !is_wr;
      pipe_idx[0] <= k;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
      case (state)
        IDLE: begin
          if (Req_SI) begin
            state   <= ISSUE;
            k       <= '0;
            is_wr   <= |WrEn_SI;
            En_SO   <= 1'b1;
            Addr_DO <= Addr_DI & ALIGN_MASK;
            Wr_DO   <= Wr_DI[SLV_DATA_BITW-1:0];
            wdata   <= Wr_DI >> SLV_DATA_BITW;
            WrEn_SO <= WrEn_SI[SB-1:0];
            wen     <= WrEn_SI >> SB;
          end
        end
        ISSUE: begin
          if (k == KW'(R-1)) begin
            En_SO   <= 1'b0;
            WrEn_SO <= '0;
            state   <= is_wr ? IDLE : DRAIN;
          end else begin
            // Remaining beats are consumed from the bottom of shift registers.
            k       <= k + 1'b1;
            Addr_DO <= Addr_DO + ADDR_BITW'(SB);
            Wr_DO   <= wdata[SLV_DATA_BITW-1:0];
            wdata   <= wdata >> SLV_DATA_BITW;
            WrEn_SO <= wen[SB-1:0];
            wen     <= wen >> SB;
          end
        end
        DRAIN: begin
          if (last_cap) begin
            state      <= RESP;
            RdValid_SO <= 1'b1;
            Rd_DO      <= cap_next;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_dwc_seq.sv
// Directed bench for bram_dwc_seq: four configurations (64/32 L1, 64/32 L3,
// 128/32 L1, 32/32 L1) sharing one clock, reset and BRAM memory image.
module tb_bram_dwc_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [256];

  // A: 64->32, latency 1
  logic a_req = 0, a_gnt, a_rv, a_en;
  logic [31:0] a_addr = 0, a_addr_o, a_wr_o, a_rdi;
  logic [7:0]  a_wen = 0;
  logic [63:0] a_wd = 0, a_rd;
  logic [3:0]  a_wen_o;
  logic [1:0]  a_st;
  // B: 64->32, latency 3
  logic b_req = 0, b_gnt, b_rv, b_en;
  logic [31:0] b_addr = 0, b_addr_o, b_wr_o, b_rdi;
  logic [7:0]  b_wen = 0;
  logic [63:0] b_wd = 0, b_rd;
  logic [3:0]  b_wen_o;
  logic [1:0]  b_st;
  logic [31:0] b_p [3];
  // C: 128->32, latency 1
  logic c_req = 0, c_gnt, c_rv, c_en;
  logic [31:0] c_addr = 0, c_addr_o, c_wr_o;
  logic [31:0] c_rdi = 32'h0;
  logic [15:0] c_wen = 0;
  logic [127:0] c_wd = 0, c_rd;
  logic [3:0]  c_wen_o;
  logic [1:0]  c_st;
  // D: 32->32, latency 1
  logic d_req = 0, d_gnt, d_rv, d_en;
  logic [31:0] d_addr = 0, d_addr_o, d_wr_o, d_rdi, d_wd = 0, d_rd;
  logic [3:0]  d_wen = 0, d_wen_o;
  logic [1:0]  d_st;

  bram_dwc_seq #(.MST_DATA_BITW(64), .SLV_DATA_BITW(32), .ADDR_BITW(32), .RD_LATENCY(1)) u_a (
    .Clk_CI(clk), .Rst_RI(rst), .Req_SI(a_req), .Gnt_SO(a_gnt), .Addr_DI(a_addr),
    .WrEn_SI(a_wen), .Wr_DI(a_wd), .RdValid_SO(a_rv), .Rd_DO(a_rd), .En_SO(a_en),
    .Addr_DO(a_addr_o), .WrEn_SO(a_wen_o), .Wr_DO(a_wr_o), .Rd_DI(a_rdi), .dbg_state(a_st));
  bram_dwc_seq #(.MST_DATA_BITW(64), .SLV_DATA_BITW(32), .ADDR_BITW(32), .RD_LATENCY(3)) u_b (
    .Clk_CI(clk), .Rst_RI(rst), .Req_SI(b_req), .Gnt_SO(b_gnt), .Addr_DI(b_addr),
    .WrEn_SI(b_wen), .Wr_DI(b_wd), .RdValid_SO(b_rv), .Rd_DO(b_rd), .En_SO(b_en),
    .Addr_DO(b_addr_o), .WrEn_SO(b_wen_o), .Wr_DO(b_wr_o), .Rd_DI(b_rdi), .dbg_state(b_st));
  bram_dwc_seq #(.MST_DATA_BITW(128), .SLV_DATA_BITW(32), .ADDR_BITW(32), .RD_LATENCY(1)) u_c (
    .Clk_CI(clk), .Rst_RI(rst), .Req_SI(c_req), .Gnt_SO(c_gnt), .Addr_DI(c_addr),
    .WrEn_SI(c_wen), .Wr_DI(c_wd), .RdValid_SO(c_rv), .Rd_DO(c_rd), .En_SO(c_en),
    .Addr_DO(c_addr_o), .WrEn_SO(c_wen_o), .Wr_DO(c_wr_o), .Rd_DI(c_rdi), .dbg_state(c_st));
  bram_dwc_seq #(.MST_DATA_BITW(32), .SLV_DATA_BITW(32), .ADDR_BITW(32), .RD_LATENCY(1)) u_d (
    .Clk_CI(clk), .Rst_RI(rst), .Req_SI(d_req), .Gnt_SO(d_gnt), .Addr_DI(d_addr),
    .WrEn_SI(d_wen), .Wr_DI(d_wd), .RdValid_SO(d_rv), .Rd_DO(d_rd), .En_SO(d_en),
    .Addr_DO(d_addr_o), .WrEn_SO(d_wen_o), .Wr_DO(d_wr_o), .Rd_DI(d_rdi), .dbg_state(d_st));

  // BRAM models: A writes and reads the shared image, B and D only read it.
  always @(posedge clk) begin
    if (a_en) begin
      for (int b = 0; b < 4; b++)
        if (a_wen_o[b]) mem[a_addr_o[9:2]][8*b +: 8] <= a_wr_o[8*b +: 8];
      a_rdi <= mem[a_addr_o[9:2]];
    end
    if (b_en) b_p[0] <= mem[b_addr_o[9:2]];
    b_p[1] <= b_p[0];
    b_p[2] <= b_p[1];
    if (d_en) d_rdi <= mem[d_addr_o[9:2]];
  end
  assign b_rdi = b_p[2];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wide read on A; call while Gnt is high. Response expected at cycle 4, Gnt back at 5.
  task automatic read_a(input string tag, input logic [31:0] addr, input logic [63:0] exp);
    a_req = 1; a_addr = addr; a_wen = 8'h00; a_wd = 64'h0;
    tick();
    for (int c = 1; c <= 5; c++) begin
      if (c == 1) begin
        a_req = 0;
        check({tag, "_wen_zero"}, a_wen_o, 4'h0);
        check({tag, "_beat0_addr"}, a_addr_o, addr & 32'hFFFF_FFF8);
      end
      check({tag, "_rvalid"}, a_rv, (c == 4));
      if (c >= 4) check({tag, "_rdata"}, a_rd, exp);
      if (c == 5) check({tag, "_gnt_back"}, a_gnt, 1'b1);
      if (c < 5) tick();
    end
  endtask

  initial begin
    int seen;
    mem[8] = 32'hAAAA0000;
    mem[9] = 32'hBBBB1111;
    for (int i = 0; i < 256; i++) if (i != 8 && i != 9) mem[i] = 32'h0;

    // reset state
    tick(); tick();
    check("rst_gnt", a_gnt, 1'b0);
    check("rst_en", a_en, 1'b0);
    check("rst_addr", a_addr_o, 32'h0);
    check("rst_rv", a_rv, 1'b0);
    check("rst_rd", a_rd, 64'h0);
    check("rst_state", a_st, 2'd0);
    rst = 0;
    #1;
    check("post_rst_gnt", a_gnt, 1'b1);

    // full 64->32 write
    a_req = 1; a_addr = 32'h10; a_wd = 64'h1122334455667788; a_wen = 8'hFF;
    tick();
    a_req = 0;
    check("w1_c1_en", a_en, 1'b1);
    check("w1_c1_addr", a_addr_o, 32'h10);
    check("w1_c1_data", a_wr_o, 32'h55667788);
    check("w1_c1_wen", a_wen_o, 4'hF);
    check("w1_c1_gnt", a_gnt, 1'b0);
    tick();
    check("w1_c2_addr", a_addr_o, 32'h14);
    check("w1_c2_data", a_wr_o, 32'h11223344);
    check("w1_c2_wen", a_wen_o, 4'hF);
    tick();
    check("w1_c3_gnt", a_gnt, 1'b1);
    check("w1_c3_en", a_en, 1'b0);

    // partial write: low slice disabled but beat still issued
    a_req = 1; a_addr = 32'h30; a_wd = 64'hDEADBEEF_CAFEF00D; a_wen = 8'hF0;
    tick();
    a_req = 0;
    check("w2_c1_en", a_en, 1'b1);
    check("w2_c1_wen", a_wen_o, 4'h0);
    check("w2_c1_data", a_wr_o, 32'hCAFEF00D);
    tick();
    check("w2_c2_wen", a_wen_o, 4'hF);
    check("w2_c2_addr", a_addr_o, 32'h34);
    tick();
    check("w2_c3_gnt", a_gnt, 1'b1);

    // reads: preloaded, full-write readback, partial-write readback
    read_a("r_pre", 32'h20, 64'hBBBB1111_AAAA0000);
    read_a("r_w1", 32'h15, 64'h1122334455667788);
    read_a("r_w2", 32'h30, 64'hDEADBEEF_00000000);

    // back-to-back writes with Req held high
    a_req = 1; a_addr = 32'h40; a_wd = 64'h0102030405060708; a_wen = 8'hFF;
    tick();
    a_addr = 32'h48; a_wd = 64'h1112131415161718;
    check("bb_c1_gnt", a_gnt, 1'b0);
    check("bb_c1_addr", a_addr_o, 32'h40);
    tick();
    check("bb_c2_gnt", a_gnt, 1'b0);
    check("bb_c2_addr", a_addr_o, 32'h44);
    check("bb_c2_data", a_wr_o, 32'h01020304);
    tick();
    check("bb_c3_gnt", a_gnt, 1'b1);
    check("bb_c3_en", a_en, 1'b0);
    tick();
    a_req = 0;
    check("bb_c4_en", a_en, 1'b1);
    check("bb_c4_addr", a_addr_o, 32'h48);
    check("bb_c4_data", a_wr_o, 32'h15161718);
    tick();
    check("bb_c5_addr", a_addr_o, 32'h4C);
    tick();
    check("bb_c6_gnt", a_gnt, 1'b1);
    read_a("r_bb1", 32'h40, 64'h0102030405060708);

    // reset during cycle 2 of a read
    a_req = 1; a_addr = 32'h20; a_wen = 8'h00;
    tick();
    a_req = 0;
    tick();
    rst = 1;
    #1;
    check("ar_gnt_in_rst", a_gnt, 1'b0);
    tick();
    check("ar_en", a_en, 1'b0);
    check("ar_addr", a_addr_o, 32'h0);
    check("ar_wdata", a_wr_o, 32'h0);
    check("ar_wen", a_wen_o, 4'h0);
    check("ar_rd", a_rd, 64'h0);
    check("ar_gnt_rst_hi", a_gnt, 1'b0);
    rst = 0;
    #1;
    check("ar_gnt_after", a_gnt, 1'b1);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (a_rv) seen++;
      tick();
    end
    check("ar_no_rvalid", seen, 0);

    // latency 3: response at cycle 6, grant back at cycle 7
    b_req = 1; b_addr = 32'h20; b_wen = 8'h00;
    tick();
    for (int c = 1; c <= 7; c++) begin
      b_req = 0;
      check("l3_rvalid", b_rv, (c == 6));
      if (c == 6) check("l3_rdata", b_rd, 64'hBBBB1111_AAAA0000);
      if (c == 7) check("l3_gnt_back", b_gnt, 1'b1);
      if (c < 7) tick();
    end

    // 128->32 near the top of the address space
    c_req = 1; c_addr = 32'hFFFFFFF0; c_wen = 16'hFFFF;
    c_wd = 128'h44444444_33333333_22222222_11111111;
    tick();
    for (int c = 1; c <= 5; c++) begin
      c_req = 0;
      if (c <= 4) begin
        check("r4_en", c_en, 1'b1);
        check("r4_addr", c_addr_o, 32'hFFFFFFF0 + 32'(4 * (c - 1)));
        check("r4_data", c_wr_o, 32'h11111111 * 32'(c));
        check("r4_gnt_busy", c_gnt, 1'b0);
        tick();
      end else begin
        check("r4_gnt_back", c_gnt, 1'b1);
        check("r4_en_off", c_en, 1'b0);
      end
    end

    // 32->32 single-beat read with unaligned address
    d_req = 1; d_addr = 32'h22; d_wen = 4'h0;
    tick();
    for (int c = 1; c <= 4; c++) begin
      d_req = 0;
      if (c == 1) check("r1_addr", d_addr_o, 32'h20);
      check("r1_rvalid", d_rv, (c == 3));
      if (c == 3) check("r1_rdata", d_rd, 32'hAAAA0000);
      if (c == 4) check("r1_gnt_back", d_gnt, 1'b1);
      if (c < 4) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
